lcd_multi_line_feed: RTL and testbench
======================================

Name: lcd_multi_line_feed

Overview:
Parametrised successor to the two-line LCD refresh sequencer. It drives a clear command, then N text-line write commands, then a refresh pause, and repeats. Every delay is a parameter. The block adds a feed enable, a forced-refresh request and an acknowledge timeout. It sits between the application text logic and the PMOD CLS SPI command driver, and all sequencing advances only on the 2.5 MHz clock enable.

Parameters:
parm_line_count, 2, number of LCD text lines written per refresh (legal range 1..4)
parm_clear_dly_ticks, 2500, ce ticks held in CLEAR_DLY after the clear is acknowledged (1 ms)
parm_line_dly_ticks, 2500, ce ticks held in LINE_DLY after each line is acknowledged
parm_refresh_ticks, 495000, ce ticks held in REFRESH_DLY after the last line
parm_ack_timeout_ticks, 25000, ce ticks a RUN state waits for ready to drop before aborting (10 ms)
parm_fast_simulation, 0, when 1, the refresh delay is divided by 100 for waveform viewing

Ports:
i_clk_20mhz  in  1  system clock
i_rst_20mhz  in  1  synchronous active-high reset
i_ce_2_5mhz  in  1  clock enable; all state and timer updates are qualified by it
i_lcd_command_ready  in  1  driver idle/ready; deasserts when a command is accepted
i_feed_enable  in  1  when 0, the FSM parks in PAUSE after finishing the current sequence
i_refresh_now  in  1  level; skips the remainder of REFRESH_DLY
o_lcd_wr_clear_display  out  1  clear request, high throughout CLEAR_RUN
o_lcd_wr_text_line  out  parm_line_count  one-hot line write request, high throughout LINE_RUN
o_lcd_line_index  out  2  index of the line currently being written
o_lcd_feed_is_idle  out  1  high in REFRESH_DLY and PAUSE
o_lcd_ack_timeout  out  1  one-clock pulse on abort due to acknowledge timeout

Behaviour:
- Decided interface: one clock i_clk_20mhz; reset i_rst_20mhz is synchronous and active-high.
- Reset values:
  - State PAUSE, timer 0, line index 0.
  - All write outputs 0, o_lcd_ack_timeout 0, o_lcd_feed_is_idle 1.
  - Reset mid-sequence aborts immediately; no request is held past the reset edge.
- Timer:
  - Width is $clog2 of the largest tick parameter, plus 1.
  - Zeroed on the ce tick where the next state differs from the present state.
  - Otherwise increments per ce tick and saturates at its maximum.
- Moore outputs decode from the registered state. The timeout pulse is registered.
- States and transitions (evaluated only when ce=1):
  - PAUSE -> CLEAR_RUN when ready=1 and feed_enable=1.
  - CLEAR_RUN -> CLEAR_DLY when ready=0.
  - CLEAR_DLY -> CLEAR_WAIT when timer == parm_clear_dly_ticks-1.
  - CLEAR_WAIT -> LINE_RUN when ready=1; line index is set to 0.
  - LINE_RUN -> LINE_DLY when ready=0.
  - LINE_DLY -> LINE_WAIT when timer == parm_line_dly_ticks-1.
  - LINE_WAIT with ready=1: if index < parm_line_count-1, increment index and go to LINE_RUN; otherwise go to REFRESH_DLY.
  - REFRESH_DLY -> PAUSE when timer == refresh_ticks-1, or when i_refresh_now=1.
- Timeout: in CLEAR_RUN or LINE_RUN, if ready stays 1 until timer == parm_ack_timeout_ticks-1, then the FSM goes to PAUSE, pulses o_lcd_ack_timeout for one clk, and resets the index to 0.
- Simultaneous events:
  - Ready drop on the timeout tick: acknowledge wins, no timeout.
  - refresh_now with timer expiry: a single transition to PAUSE.
  - feed_enable=0 mid-sequence: the sequence completes; the block holds in PAUSE.
- parm_line_count=1: LINE_WAIT goes straight to REFRESH_DLY.
- Indices >= parm_line_count are never produced.

Optional Feature:
LCD_FEED_TIMEOUT_EN:
- Defined: acknowledge timeout logic and o_lcd_ack_timeout are active as described.
- Undefined: RUN states wait indefinitely for ready=0, and o_lcd_ack_timeout is tied to 0.

Decomposition:
- Package lcd_feed_pkg holds:
  - t_lcd_feed_state enum (PAUSE, CLEAR_RUN, CLEAR_DLY, CLEAR_WAIT, LINE_RUN, LINE_DLY, LINE_WAIT, REFRESH_DLY), 4-bit encoding.
  - Constant c_lcd_max_lines=4.
  - Function computing the timer width from the tick parameters.
- Sub-module lcd_feed_tick_timer: ce-qualified, clear-on-change, saturating counter parametrised by width.

Test Plan:
Bench parameters: lines=3, clear=4, line=4, refresh=20, timeout=8 (fast_sim 0).
- Reset, then ready=1 and feed_enable=1 -> clear is high on the next ce tick. Responder drops ready for 1 tick per command; expect clear, then line one-hots 001, 010, 100, each request ending on ready=0. Idle rises in REFRESH_DLY for 20 ticks, then CLEAR_RUN restarts.
- Hold ready=1 in CLEAR_RUN -> after 8 ce ticks, timeout pulses once (1 clk) and the FSM is in PAUSE. With the macro undefined, the FSM stays in CLEAR_RUN forever.
- Assert refresh_now at REFRESH_DLY tick 3 -> PAUSE on the next ce tick, then CLEAR_RUN.
- Drop feed_enable during the line-2 write -> lines 2 and 3 complete, REFRESH_DLY runs, then the FSM stays in PAUSE. Restoring enable restarts at clear.
- Assert reset during LINE_DLY of line 1 -> next clk: all requests 0, index 0, idle 1.
- Hold ce=0 for 50 clocks mid-sequence -> state, timer and outputs remain unchanged.

Source files
------------

// File: rtl/lcd_feed_pkg.sv
// Shared types and helpers for the multi-line LCD feed sequencer.
// The LCD_FEED_TIMEOUT_EN macro (see lcd_multi_line_feed) needs nothing from this package.
package lcd_feed_pkg;

  typedef enum logic [3:0] {
    PAUSE       = 4'd0,
    CLEAR_RUN   = 4'd1,
    CLEAR_DLY   = 4'd2,
    CLEAR_WAIT  = 4'd3,
    LINE_RUN    = 4'd4,
    LINE_DLY    = 4'd5,
    LINE_WAIT   = 4'd6,
    REFRESH_DLY = 4'd7
  } t_lcd_feed_state;

  localparam int c_lcd_max_lines = 4;

  // The extra bit keeps the timer comfortably clear of its saturation value.
  function automatic int f_timer_width(input int clear_ticks, input int line_ticks,
                                       input int refresh_ticks, input int timeout_ticks);
    int m;
    m = clear_ticks;
    if (line_ticks > m) m = line_ticks;
    if (refresh_ticks > m) m = refresh_ticks;
    if (timeout_ticks > m) m = timeout_ticks;
    return $clog2(m) + 1;
  endfunction

  function automatic int f_refresh_ticks(input int refresh_ticks, input int fast_sim);
    int r;
    r = (fast_sim != 0) ? (refresh_ticks / 100) : refresh_ticks;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/lcd_feed_tick_timer.sv
// Clock-enable qualified tick counter: clears on request, otherwise counts and saturates.
module lcd_feed_tick_timer #(
  parameter int parm_width = 4
) (
  input  logic                  i_clk_20mhz,
  input  logic                  i_rst_20mhz,
  input  logic                  i_ce_2_5mhz,
  input  logic                  i_clear,
  output logic [parm_width-1:0] o_count
);

  logic [parm_width-1:0] r_count;

  // Counter register; holds its value whenever the enable is low.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_count <= '0;
    end else if (i_ce_2_5mhz) begin
      if (i_clear) begin
        r_count <= '0;
      end else if (r_count != {parm_width{1'b1}}) begin
        r_count <= r_count + parm_width'(1);
      end
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/lcd_multi_line_feed.sv
// Clear / N-line / refresh-pause command sequencer for the PMOD CLS driver.
// Define LCD_FEED_TIMEOUT_EN to enable the acknowledge timeout abort.
module lcd_multi_line_feed
  import lcd_feed_pkg::*;
#(
  parameter int parm_line_count        = 2,
  parameter int parm_clear_dly_ticks   = 2500,
  parameter int parm_line_dly_ticks    = 2500,
  parameter int parm_refresh_ticks     = 495000,
  parameter int parm_ack_timeout_ticks = 25000,
  parameter int parm_fast_simulation   = 0
) (
  input  logic                       i_clk_20mhz,
  input  logic                       i_rst_20mhz,
  input  logic                       i_ce_2_5mhz,
  input  logic                       i_lcd_command_ready,
  input  logic                       i_feed_enable,
  input  logic                       i_refresh_now,
  output logic                       o_lcd_wr_clear_display,
  output logic [parm_line_count-1:0] o_lcd_wr_text_line,
  output logic [1:0]                 o_lcd_line_index,
  output logic                       o_lcd_feed_is_idle,
  output logic                       o_lcd_ack_timeout
);

  localparam int c_refresh_eff = f_refresh_ticks(parm_refresh_ticks, parm_fast_simulation);
  localparam int c_timer_w = f_timer_width(parm_clear_dly_ticks, parm_line_dly_ticks,
                                           parm_refresh_ticks, parm_ack_timeout_ticks);
  localparam logic [c_timer_w-1:0] c_clear_last   = c_timer_w'(parm_clear_dly_ticks - 1);
  localparam logic [c_timer_w-1:0] c_line_last    = c_timer_w'(parm_line_dly_ticks - 1);
  localparam logic [c_timer_w-1:0] c_refresh_last = c_timer_w'(c_refresh_eff - 1);
`ifdef LCD_FEED_TIMEOUT_EN
  localparam logic [c_timer_w-1:0] c_timeout_last = c_timer_w'(parm_ack_timeout_ticks - 1);
`endif
  localparam logic [1:0] c_last_index = 2'(parm_line_count - 1);

  t_lcd_feed_state             r_state;
  t_lcd_feed_state             w_next_state;
  logic [1:0]                  r_index;
  logic [1:0]                  w_next_index;
  logic                        w_timeout;
  logic [c_timer_w-1:0]        w_timer;
  logic                        w_timer_clear;
  logic [parm_line_count-1:0]  w_line_onehot;
  logic                        r_clear;
  logic [parm_line_count-1:0]  r_text_line;
  logic                        r_idle;
  logic                        r_timeout;

  assign w_timer_clear = (w_next_state != r_state);

  lcd_feed_tick_timer #(.parm_width(c_timer_w)) u_timer (
    .i_clk_20mhz (i_clk_20mhz),
    .i_rst_20mhz (i_rst_20mhz),
    .i_ce_2_5mhz (i_ce_2_5mhz),
    .i_clear     (w_timer_clear),
    .o_count     (w_timer)
  );

  // Next-state, next-index and timeout-abort decision.
  always_comb begin
    w_next_state = r_state;
    w_next_index = r_index;
    w_timeout    = 1'b0;
    case (r_state)
      PAUSE: begin
        if (i_lcd_command_ready && i_feed_enable) w_next_state = CLEAR_RUN;
        else w_next_state = PAUSE;
      end
      CLEAR_RUN, LINE_RUN: begin
        // A ready drop on the timeout tick counts as an acknowledge.
        if (!i_lcd_command_ready) begin
          w_next_state = (r_state == CLEAR_RUN) ? CLEAR_DLY : LINE_DLY;
        end
`ifdef LCD_FEED_TIMEOUT_EN
        else if (w_timer == c_timeout_last) begin
          w_next_state = PAUSE;
          w_next_index = 2'd0;
          w_timeout    = 1'b1;
        end
`endif
        else begin
          w_next_state = r_state;
        end
      end
      CLEAR_DLY: begin
        if (w_timer == c_clear_last) w_next_state = CLEAR_WAIT;
        else w_next_state = CLEAR_DLY;
      end
      CLEAR_WAIT: begin
        if (i_lcd_command_ready) begin
          w_next_state = LINE_RUN;
          w_next_index = 2'd0;
        end else begin
          w_next_state = CLEAR_WAIT;
        end
      end
      LINE_DLY: begin
        if (w_timer == c_line_last) w_next_state = LINE_WAIT;
        else w_next_state = LINE_DLY;
      end
      LINE_WAIT: begin
        if (!i_lcd_command_ready) begin
          w_next_state = LINE_WAIT;
        end else if (r_index < c_last_index) begin
          w_next_state = LINE_RUN;
          w_next_index = r_index + 2'd1;
        end else begin
          w_next_state = REFRESH_DLY;
        end
      end
      REFRESH_DLY: begin
        if (i_refresh_now || (w_timer == c_refresh_last)) w_next_state = PAUSE;
        else w_next_state = REFRESH_DLY;
      end
      default: begin
        w_next_state = PAUSE;
        w_next_index = 2'd0;
      end
    endcase
  end

  // One-hot line request decoded from the next state so the output register matches it.
  always_comb begin
    w_line_onehot = '0;
    for (int i = 0; i < parm_line_count; i++) begin
      w_line_onehot[i] = (w_next_state == LINE_RUN) && (w_next_index == 2'(i));
    end
  end

  // State, index and registered Moore outputs; the timeout pulse lasts one clk.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_state     <= PAUSE;
      r_index     <= 2'd0;
      r_clear     <= 1'b0;
      r_text_line <= '0;
      r_idle      <= 1'b1;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= i_ce_2_5mhz && w_timeout;
      if (i_ce_2_5mhz) begin
        r_state     <= w_next_state;
        r_index     <= w_next_index;
        r_clear     <= (w_next_state == CLEAR_RUN);
        r_text_line <= w_line_onehot;
        r_idle      <= (w_next_state == REFRESH_DLY) || (w_next_state == PAUSE);
      end
    end
  end

  assign o_lcd_wr_clear_display = r_clear;
  assign o_lcd_wr_text_line     = r_text_line;
  assign o_lcd_line_index       = r_index;
  assign o_lcd_feed_is_idle     = r_idle;
  assign o_lcd_ack_timeout      = r_timeout;

endmodule

// File: tb/tb_lcd_multi_line_feed.sv
// Directed bench for lcd_multi_line_feed: lines=3, clear=4, line=4, refresh=20, timeout=8.
module tb_lcd_multi_line_feed;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       ready;
  logic       feed;
  logic       refresh_now;
  logic       o_clr;
  logic [2:0] o_line;
  logic [1:0] o_idx;
  logic       o_idle;
  logic       o_to;
  logic [1:0] to_idx;
  int         total = 0;
  int         bad = 0;

  lcd_multi_line_feed #(
    .parm_line_count(3), .parm_clear_dly_ticks(4), .parm_line_dly_ticks(4),
    .parm_refresh_ticks(20), .parm_ack_timeout_ticks(8), .parm_fast_simulation(0)
  ) dut (
    .i_clk_20mhz            (clk),
    .i_rst_20mhz            (rst),
    .i_ce_2_5mhz            (ce),
    .i_lcd_command_ready    (ready),
    .i_feed_enable          (feed),
    .i_refresh_now          (refresh_now),
    .o_lcd_wr_clear_display (o_clr),
    .o_lcd_wr_text_line     (o_line),
    .o_lcd_line_index       (o_idx),
    .o_lcd_feed_is_idle     (o_idle),
    .o_lcd_ack_timeout      (o_to)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One ce pulse; returns at the falling edge after the enabled rising edge.
  task automatic tick();
    @(negedge clk);
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_out(input string tag, input logic c, input logic [2:0] l,
                            input logic [1:0] x, input logic idl);
    check_val(tag, 32'({o_clr, o_line, o_idx, o_idle}), 32'({c, l, x, idl}));
  endtask

  // Responder drops ready for one tick, then the 4-tick delay and the wait tick follow.
  task automatic ack_cycle(input string tag, input logic c, input logic [2:0] l,
                           input logic [1:0] x, input logic idl);
    ready = 1'b0;
    tick();
    ready = 1'b1;
    check_val({tag, "_ack"}, 32'({o_clr, o_line, o_idle}), 32'd0);
    check_val({tag, "_ack_to"}, 32'(o_to), 32'd0);
    ticks(4);
    check_val({tag, "_dly"}, 32'({o_clr, o_line, o_idle}), 32'd0);
    tick();
    expect_out(tag, c, l, x, idl);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; ready = 1'b0; feed = 1'b0; refresh_now = 1'b0;
    repeat (3) @(negedge clk);
    expect_out("reset", 1'b0, 3'b000, 2'd0, 1'b1);
    check_val("reset_to", 32'(o_to), 32'd0);
    rst = 1'b0;

    // Normal sequence: clear, three lines, full refresh pause, restart.
    ready = 1'b1; feed = 1'b1;
    tick();
    expect_out("clear_req", 1'b1, 3'b000, 2'd0, 1'b0);
    ack_cycle("line0", 1'b0, 3'b001, 2'd0, 1'b0);
    ack_cycle("line1", 1'b0, 3'b010, 2'd1, 1'b0);
    ack_cycle("line2", 1'b0, 3'b100, 2'd2, 1'b0);
    ack_cycle("refresh", 1'b0, 3'b000, 2'd2, 1'b1);
    ticks(19);
    expect_out("refresh19", 1'b0, 3'b000, 2'd2, 1'b1);
    tick();
    expect_out("refresh_end", 1'b0, 3'b000, 2'd2, 1'b1);
    tick();
    expect_out("restart", 1'b1, 3'b000, 2'd2, 1'b0);

    // Ready held high in CLEAR_RUN.
    ticks(7);
    expect_out("to_pre", 1'b1, 3'b000, 2'd2, 1'b0);
    check_val("to_pre_pulse", 32'(o_to), 32'd0);
    tick();
`ifdef LCD_FEED_TIMEOUT_EN
    expect_out("to_pause", 1'b0, 3'b000, 2'd0, 1'b1);
    check_val("to_pulse", 32'(o_to), 32'd1);
    @(negedge clk);
    check_val("to_pulse_end", 32'(o_to), 32'd0);
    tick();
    expect_out("to_restart", 1'b1, 3'b000, 2'd0, 1'b0);
    to_idx = 2'd0;
`else
    expect_out("to_hold", 1'b1, 3'b000, 2'd2, 1'b0);
    check_val("to_hold_pulse", 32'(o_to), 32'd0);
    ticks(10);
    expect_out("to_hold_long", 1'b1, 3'b000, 2'd2, 1'b0);
    to_idx = 2'd2;
`endif
    check_val("to_idx", 32'(o_idx), 32'(to_idx));

    // Ready drop on the would-be timeout tick is an acknowledge.
    ticks(7);
    ack_cycle("ack_wins", 1'b0, 3'b001, 2'd0, 1'b0);
    ack_cycle("rf_line1", 1'b0, 3'b010, 2'd1, 1'b0);
    ack_cycle("rf_line2", 1'b0, 3'b100, 2'd2, 1'b0);
    ack_cycle("rf_enter", 1'b0, 3'b000, 2'd2, 1'b1);
    ticks(3);
    refresh_now = 1'b1;
    tick();
    expect_out("rf_pause", 1'b0, 3'b000, 2'd2, 1'b1);
    refresh_now = 1'b0;
    tick();
    expect_out("rf_restart", 1'b1, 3'b000, 2'd2, 1'b0);

    // Feed enable dropped while line 2 is being written.
    ack_cycle("fd_line0", 1'b0, 3'b001, 2'd0, 1'b0);
    ack_cycle("fd_line1", 1'b0, 3'b010, 2'd1, 1'b0);
    feed = 1'b0;
    ack_cycle("fd_line2", 1'b0, 3'b100, 2'd2, 1'b0);
    ack_cycle("fd_refresh", 1'b0, 3'b000, 2'd2, 1'b1);
    ticks(25);
    expect_out("fd_park", 1'b0, 3'b000, 2'd2, 1'b1);
    feed = 1'b1;
    tick();
    expect_out("fd_restart", 1'b1, 3'b000, 2'd2, 1'b0);

    // Reset while in LINE_DLY of line 1.
    ack_cycle("rs_line0", 1'b0, 3'b001, 2'd0, 1'b0);
    ready = 1'b0;
    tick();
    ready = 1'b1;
    ticks(2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    expect_out("rst_mid", 1'b0, 3'b000, 2'd0, 1'b1);
    check_val("rst_mid_to", 32'(o_to), 32'd0);
    rst = 1'b0;
    tick();
    expect_out("rst_restart", 1'b1, 3'b000, 2'd0, 1'b0);

    // Clock enable held low mid-sequence freezes everything.
    ready = 1'b0;
    tick();
    ready = 1'b1;
    ticks(2);
    repeat (50) @(negedge clk);
    expect_out("hold_dly", 1'b0, 3'b000, 2'd0, 1'b0);
    ticks(2);
    expect_out("hold_wait", 1'b0, 3'b000, 2'd0, 1'b0);
    tick();
    expect_out("hold_line", 1'b0, 3'b001, 2'd0, 1'b0);
    ready = 1'b0;
    repeat (50) @(negedge clk);
    expect_out("hold_run", 1'b0, 3'b001, 2'd0, 1'b0);
    tick();
    expect_out("hold_run_ack", 1'b0, 3'b000, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
